dds_pwm_dac: RTL and testbench

DDS_PWM_DAC -- requirements
Module: dds_pwm_dac

---
 rtl/dds_pwm_dac.sv | 97 +++++++++
 tb/tb_dds_pwm_dac.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/dds_pwm_dac.sv
// PWM DAC fed by a DDS sample stream. A one-entry pending buffer holds the next duty value.
// Define DDS_PWM_SIGNED_EN to treat samples as two's complement and store them as offset binary.
module dds_pwm_dac #(
  parameter int data_width = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [data_width-1:0] sample_in,
  input  logic                  sample_valid,
  output logic                  sample_ready,
  output logic                  pwm_out,
  output logic                  period_start,
  output logic                  underrun,
  output logic                  busy
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [data_width-1:0] CNT_MAX = '1;

  state_t                state, state_next;
  logic [data_width-1:0] counter, counter_next;
  logic [data_width-1:0] duty, duty_next;
  logic [data_width-1:0] pend_data, pend_data_next;
  logic                  pend_valid, pend_valid_next;
  logic [data_width-1:0] stored;
  logic                  transfer, wrap, boundary;

`ifdef DDS_PWM_SIGNED_EN
  assign stored = {~sample_in[data_width-1], sample_in[data_width-2:0]};
`else
  assign stored = sample_in;
`endif

  assign sample_ready = ~pend_valid;
  assign transfer     = sample_valid & ~pend_valid;
  assign busy         = (state == RUN);
  // A boundary is any edge that enters period cycle 0: starting from IDLE or wrapping while still enabled.
  assign wrap         = (state == RUN) && (counter == CNT_MAX) && en;
  assign boundary     = ((state == IDLE) && en) || wrap;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next   = state;
    counter_next = '0;
    case (state)
      IDLE: if (en) state_next = RUN;
      RUN: begin
        counter_next = counter + 1'b1;
        if ((counter == CNT_MAX) && !en) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // An incoming sample bypasses the buffer only when it lands on a boundary with the buffer empty.
  always_comb begin
    duty_next       = duty;
    pend_valid_next = pend_valid;
    pend_data_next  = pend_data;
    if (boundary && pend_valid) begin
      duty_next       = pend_data;
      pend_valid_next = 1'b0;
    end else if (boundary && transfer) begin
      duty_next = stored;
    end else if (transfer) begin
      pend_valid_next = 1'b1;
      pend_data_next  = stored;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      counter      <= '0;
      duty         <= '0;
      pend_valid   <= 1'b0;
      pend_data    <= '0;
      pwm_out      <= 1'b0;
      period_start <= 1'b0;
      underrun     <= 1'b0;
    end else begin
      counter      <= counter_next;
      duty         <= duty_next;
      pend_valid   <= pend_valid_next;
      pend_data    <= pend_data_next;
      pwm_out      <= (state_next == RUN) && (counter_next < duty_next);
      period_start <= boundary;
      underrun     <= wrap && !pend_valid && !transfer;
    end
  end

endmodule

// File: tb/tb_dds_pwm_dac.sv
// Scoreboard bench for dds_pwm_dac: accepted samples are queued and matched against each PWM period.
// Expected duty values follow DDS_PWM_SIGNED_EN when the bench is built with it.
module tb_dds_pwm_dac;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [7:0] sample_in;
  logic       sample_valid;
  logic       sample_ready;
  logic       pwm_out;
  logic       period_start;
  logic       underrun;
  logic       busy;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_q[$];
  logic [7:0] cur_duty = 8'd0;
  bit         in_period = 1'b0;
  int         phase_len = 0;

  dds_pwm_dac #(.data_width(8)) dut (
    .clk(clk), .rst(rst), .en(en), .sample_in(sample_in), .sample_valid(sample_valid),
    .sample_ready(sample_ready), .pwm_out(pwm_out), .period_start(period_start),
    .underrun(underrun), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] exp_duty(input logic [7:0] s);
`ifdef DDS_PWM_SIGNED_EN
    return s ^ 8'h80;
`else
    return s;
`endif
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s got %0d expected %0d at %0t", tag, observed, expected, $time);
    end
  endtask

  // Offers one sample as soon as the buffer is free and records it once it is accepted.
  task automatic applyStimulus(input logic [7:0] s);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!sample_ready && n < 1000);
    if (!sample_ready) checkOutput("ready_timeout", 0, 1);
    else begin
      sample_in    = s;
      sample_valid = 1'b1;
      @(posedge clk);
      exp_q.push_back(exp_duty(s));
      #1 sample_valid = 1'b0;
    end
  endtask

  task automatic wait_period_start();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!period_start && n < 600);
    if (!period_start) checkOutput("period_timeout", 0, 1);
  endtask

  task automatic check_reset_values(input string tag);
    checkOutput({tag, "_pwm"}, pwm_out, 0);
    checkOutput({tag, "_pstart"}, period_start, 0);
    checkOutput({tag, "_underrun"}, underrun, 0);
    checkOutput({tag, "_busy"}, busy, 0);
    checkOutput({tag, "_ready"}, sample_ready, 1);
  endtask

  // Period monitor: every period must last 256 cycles and follow the duty popped at its start.
  always @(negedge clk) begin
    if (!rst) begin
      in_period = 1'b0;
      exp_q.delete();
    end else if (period_start) begin
      if (in_period) checkOutput("period_len", phase_len, 256);
      checkOutput("underrun", underrun, in_period && (exp_q.size() == 0));
      if (exp_q.size() > 0) cur_duty = exp_q.pop_front();
      in_period = 1'b1;
      checkOutput("pwm", pwm_out, 0 < cur_duty);
      phase_len = 1;
    end else if (in_period) begin
      if (busy) begin
        checkOutput("pwm", pwm_out, phase_len < int'(cur_duty));
        checkOutput("underrun_mid", underrun, 0);
        phase_len++;
      end else begin
        checkOutput("period_len", phase_len, 256);
        in_period = 1'b0;
      end
    end else begin
      checkOutput("idle_pwm", pwm_out, 0);
    end
  end

  initial begin
    #3000000;
    $display("[TB] FAIL global_timeout");
    $fatal(1, "[TB] simulation did not finish");
  end

  initial begin
    int n;
    int accepted;
    int ps;
    logic [7:0] next_val;
    logic rdy;
    logic [7:0] sweep[3];

    rst = 1'b0; en = 1'b0; sample_valid = 1'b0; sample_in = 8'd0;
    repeat (3) @(negedge clk);
    check_reset_values("reset");
    rst = 1'b1;

    // Single sample then free run: underrun from the second period on.
    applyStimulus(8'd64);
    @(negedge clk) en = 1'b1;
    wait_period_start();
    checkOutput("ready_first", sample_ready, 1);
    repeat (3) wait_period_start();

    // Extremes on consecutive periods.
    applyStimulus(8'd0);
    wait_period_start();
    checkOutput("ready_bound0", sample_ready, 1);
    applyStimulus(8'd255);
    wait_period_start();
    checkOutput("ready_bound1", sample_ready, 1);

    // Sample arriving on the boundary edge with an empty buffer goes straight to duty.
    repeat (255) @(negedge clk);
    checkOutput("bypass_ready", sample_ready, 1);
    sample_in = 8'd200; sample_valid = 1'b1;
    @(posedge clk);
    exp_q.push_back(exp_duty(8'd200));
    #1 sample_valid = 1'b0;
    wait_period_start();
    wait_period_start();

    // Continuous valid: one transfer at start plus one after each of 4 boundaries.
    accepted = 0; ps = 0; next_val = 8'd11;
    while (ps < 4) begin
      @(negedge clk);
      if (period_start) ps++;
      sample_in = next_val; sample_valid = 1'b1; rdy = sample_ready;
      @(posedge clk);
      if (rdy) begin
        exp_q.push_back(exp_duty(next_val));
        accepted++;
        next_val = next_val + 8'd37;
      end
    end
    #1 sample_valid = 1'b0;
    checkOutput("stream_count", accepted, 5);

    // Drop en mid-period: the period completes and busy falls after counter 255.
    wait_period_start();
    repeat (50) @(negedge clk);
    en = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (busy && n < 400);
    checkOutput("busy_fall", n, 206);
    repeat (20) @(negedge clk);
    checkOutput("idle_pstart", period_start, 0);

    // Reset at counter 100 with a sample pending.
    applyStimulus(8'd150);
    @(negedge clk) en = 1'b1;
    wait_period_start();
    applyStimulus(8'd33);
    repeat (99) @(negedge clk);
    checkOutput("pre_rst_ready", sample_ready, 0);
    checkOutput("pre_rst_pwm", pwm_out, 1);
    rst = 1'b0; en = 1'b0;
    #1 check_reset_values("midrst");
    repeat (3) @(negedge clk);
    rst = 1'b1;

    // Sign-convention sweep; the discarded 33 must not reappear.
    sweep[0] = 8'h80; sweep[1] = 8'h00; sweep[2] = 8'h7F;
    applyStimulus(sweep[0]);
    @(negedge clk) en = 1'b1;
    wait_period_start();
    for (int i = 1; i < 3; i++) begin
      applyStimulus(sweep[i]);
      wait_period_start();
    end
    en = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (busy && n < 400);
    checkOutput("final_idle", busy, 0);
    repeat (5) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
